// File: rtl/pixel_readout_ctrl.sv
// Pixel array sequencer (ERASE/EXPOSE/CONVERT/READ) with ramp generation and a valid/ready pixel stream.
// Define PIXEL_READOUT_GRAY_EN to drive a Gray-coded ramp and decode captured words back to binary.
module pixel_readout_ctrl #(
  parameter int DATA_W     = 8,
  parameter int NUM_PIX    = 4,
  parameter int ERASE_CYC  = 5,
  parameter int EXPOSE_CYC = 255,
  parameter int READ_CYC   = 2,
  localparam int IDX_W     = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_i,
  input  logic                        cont_i,
  output logic                        erase_o,
  output logic                        expose_o,
  output logic                        convert_o,
  output logic                        read_o,
  output logic [DATA_W-1:0]           ramp_data_o,
  output logic                        ramp_oe_o,
  input  logic [NUM_PIX*DATA_W-1:0]   pix_data_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [DATA_W-1:0]           out_data_o,
  output logic [IDX_W-1:0]            out_idx_o,
  output logic                        frame_done_o,
  output logic                        busy_o
);

  localparam int CONV_CYC = 2 ** DATA_W;
  localparam int MAX_AB   = (ERASE_CYC > EXPOSE_CYC) ? ERASE_CYC : EXPOSE_CYC;
  localparam int MAX_CR   = (CONV_CYC > READ_CYC) ? CONV_CYC : READ_CYC;
  localparam int MAX_CYC  = (MAX_AB > MAX_CR) ? MAX_AB : MAX_CR;
  localparam int CNT_W    = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {IDLE, ERASE, EXPOSE, CONVERT, READ, OUT} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               capture;
  logic [DATA_W-1:0]  cap_reg  [NUM_PIX];
  logic [DATA_W-1:0]  cap_word [NUM_PIX];
  logic [DATA_W-1:0]  cnt_low;
  logic [DATA_W-1:0]  ramp_code;

`ifdef PIXEL_READOUT_GRAY_EN
  function automatic logic [DATA_W-1:0] gray2bin(input logic [DATA_W-1:0] g);
    logic [DATA_W-1:0] b;
    b[DATA_W-1] = g[DATA_W-1];
    for (int i = DATA_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction
`endif

  // Decoding happens before the capture register so latency matches the binary build.
  generate
    for (genvar gi = 0; gi < NUM_PIX; gi++) begin : g_cap
`ifdef PIXEL_READOUT_GRAY_EN
      assign cap_word[gi] = gray2bin(pix_data_i[gi*DATA_W +: DATA_W]);
`else
      assign cap_word[gi] = pix_data_i[gi*DATA_W +: DATA_W];
`endif
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      for (int i = 0; i < NUM_PIX; i++) cap_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      if (capture) begin
        for (int i = 0; i < NUM_PIX; i++) cap_reg[i] <= cap_word[i];
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg + 1'b1;
    idx_next     = idx_reg;
    capture      = 1'b0;
    frame_done_o = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (start_i) state_next = ERASE;
      end
      ERASE: begin
        if (cnt_reg == CNT_W'(ERASE_CYC - 1)) begin
          state_next = EXPOSE;
          cnt_next   = '0;
        end
      end
      EXPOSE: begin
        if (cnt_reg == CNT_W'(EXPOSE_CYC - 1)) begin
          state_next = CONVERT;
          cnt_next   = '0;
        end
      end
      CONVERT: begin
        if (cnt_reg == CNT_W'(CONV_CYC - 1)) begin
          state_next = READ;
          cnt_next   = '0;
        end
      end
      READ: begin
        if (cnt_reg == CNT_W'(READ_CYC - 1)) begin
          state_next = OUT;
          cnt_next   = '0;
          idx_next   = '0;
          capture    = 1'b1;
        end
      end
      OUT: begin
        cnt_next = '0;
        if (out_ready_i) begin
          if (idx_reg == IDX_W'(NUM_PIX - 1)) begin
            frame_done_o = 1'b1;
            idx_next     = '0;
            state_next   = cont_i ? ERASE : IDLE;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign erase_o     = (state_reg == ERASE);
  assign expose_o    = (state_reg == EXPOSE);
  assign convert_o   = (state_reg == CONVERT);
  assign read_o      = (state_reg == READ);
  assign busy_o      = (state_reg != IDLE);
  assign out_valid_o = (state_reg == OUT);
  assign ramp_oe_o   = ~read_o;

  assign cnt_low = cnt_reg[DATA_W-1:0];
`ifdef PIXEL_READOUT_GRAY_EN
  assign ramp_code = cnt_low ^ (cnt_low >> 1);
`else
  assign ramp_code = cnt_low;
`endif
  assign ramp_data_o = convert_o ? ramp_code : '0;

  assign out_data_o = out_valid_o ? cap_reg[idx_reg] : '0;
  assign out_idx_o  = out_valid_o ? idx_reg : '0;

endmodule
